iob_eth_tx_arb: RTL and testbench

IOB_ETH_TX_ARB -- requirements
Module: iob_eth_tx_arb

---
 rtl/iob_eth_tx_arb.sv | 145 ++++++++++++++
 tb/tb_iob_eth_tx_arb.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/iob_eth_tx_arb.sv
// iob_eth_tx_arb -- two-requester round-robin arbiter in front of an Ethernet
// transmitter. It grants one frame buffer at a time, hands its length and a
// send strobe to the transmitter, waits for the frame to finish, then holds
// off for an inter-frame gap before arbitrating again.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   req[1:0]   per-requester level request, held until done/err
//   nbytes0/1  frame length per requester (preamble included)
//   gnt[1:0]   one-hot grant, selects the buffer onto the transmitter read port
//   done[1:0]  one-cycle completion pulse to the granted requester
//   err[1:0]   one-cycle rejection/timeout pulse to the granted requester
//   tx_send    send strobe to the transmitter
//   tx_nbytes  latched frame length for the transmitter
//   tx_ready   transmitter idle flag (low while a frame is in flight)
//   busy       high whenever the arbiter is not idle
module iob_eth_tx_arb #(
  parameter int NBYTES_W    = 11,
  parameter int IFG_CYCLES  = 24,  // must be >= 1
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [NBYTES_W-1:0] nbytes0,
  input  logic [NBYTES_W-1:0] nbytes1,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [1:0]          err,
  output logic                tx_send,
  output logic [NBYTES_W-1:0] tx_nbytes,
  input  logic                tx_ready,
  output logic                busy
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, GAP} state_t;

  state_t              state, state_nxt;
  logic                last_gnt;   // index of the requester granted last
  logic [GAP_W-1:0]    gap_cnt;
  logic [TO_W-1:0]     to_cnt;     // cycles spent in SEND so far
  logic [1:0]          win;
  logic [NBYTES_W-1:0] win_nbytes;
  logic                zero_len;
  logic                timed_out;
  logic                abort;

  // Round-robin pick: on a tie the requester that did not win last time goes.
  always_comb begin
    win = 2'b00;
    unique case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last_gnt ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

  assign win_nbytes = win[1] ? nbytes1 : nbytes0;

  // A zero-length frame is rejected in the first SEND cycle before any strobe;
  // timed_out fires one cycle after the last strobe cycle, so the strobe is
  // seen for exactly ACK_TIMEOUT cycles.
  assign zero_len  = (tx_nbytes == '0);
  assign timed_out = (to_cnt == TO_W'(ACK_TIMEOUT));
  assign abort     = zero_len || timed_out;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (req != 2'b00) state_nxt = SEND;
      SEND:      if (abort)        state_nxt = IDLE;
                 else if (!tx_ready) state_nxt = WAIT_DONE;
      WAIT_DONE: if (tx_ready)     state_nxt = GAP;
      GAP:       if (gap_cnt == '0) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode. err is raised while still in SEND (gnt still held) so the
  // requester drops req before the arbiter is back in IDLE; otherwise it
  // would be re-granted on the same stale request.
  always_comb begin
    busy    = (state != IDLE);
    tx_send = 1'b0;
    err     = 2'b00;
    if (state == SEND) begin
      tx_send = !abort;
      if (abort) err = gnt;
    end
  end

  // Grant, length latch, done pulse and counters. done is registered so it
  // lands in the first GAP cycle; the gap counter then runs IFG_CYCLES-1..0
  // and IDLE follows exactly IFG_CYCLES cycles after the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt       <= 2'b00;
      done      <= 2'b00;
      tx_nbytes <= '0;
      last_gnt  <= 1'b1;
      gap_cnt   <= '0;
      to_cnt    <= '0;
    end else begin
      done <= 2'b00;
      unique case (state)
        IDLE: begin
          if (req != 2'b00) begin
            gnt       <= win;
            tx_nbytes <= win_nbytes;
            last_gnt  <= win[1];
            to_cnt    <= '0;
          end
        end
        SEND: begin
          if (abort)         gnt    <= 2'b00;
          else if (tx_ready) to_cnt <= to_cnt + TO_W'(1);
        end
        WAIT_DONE: begin
          if (tx_ready) begin
            done    <= gnt;
            gnt     <= 2'b00;
            gap_cnt <= GAP_W'(IFG_CYCLES - 1);
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_tx_arb.sv
// Bench for iob_eth_tx_arb: a cycle table for reset, zero-length, timeout and
// tie-break behaviour, then hand sequences for full frames with a transmitter
// handshake, round-robin alternation, request disturbance and mid-frame reset.
module tb_iob_eth_tx_arb;
  localparam int NW = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [NW-1:0] nbytes0, nbytes1;
  logic          tx_ready;
  logic [1:0]    gnt, done, err;
  logic          tx_send;
  logic [NW-1:0] tx_nbytes;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iob_eth_tx_arb #(.NBYTES_W(NW), .IFG_CYCLES(24), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .nbytes0(nbytes0), .nbytes1(nbytes1),
    .gnt(gnt), .done(done), .err(err), .tx_send(tx_send), .tx_nbytes(tx_nbytes),
    .tx_ready(tx_ready), .busy(busy)
  );

  typedef struct {
    logic          rst_n;
    logic [1:0]    req;
    logic [NW-1:0] nb0, nb1;
    logic          rdy;
    logic [1:0]    gnt, done, err;
    logic          send;
    logic [NW-1:0] txn;
    logic          busy;
  } vec_t;

  vec_t vq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Structural invariants every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1)
      check("invariant",
            64'({$onehot0(gnt), !(|done && |err), $onehot0(done), $onehot0(err),
                 !tx_send || (gnt != 2'b00), (err & ~gnt) == 2'b00}),
            64'(6'b111111));
  end

  // One frame with a well-behaved transmitter: idle drops 2 cycles after the
  // strobe is seen, stays low 150 cycles, then rises.
  task automatic run_frame(input logic [1:0] g, input logic [NW-1:0] n,
                           input bit drop, input bit disturb);
    int k;
    bit stable;
    k = 0;
    while (gnt == 2'b00 && k < 60) begin step(); k++; end
    check("grant", 64'(gnt), 64'(g));
    check("grant_len_send", 64'({tx_nbytes, tx_send}), 64'({n, 1'b1}));
    if (disturb) begin
      nbytes0 = ~n;
      req[0]  = 1'b0;
    end
    step();
    step();
    tx_ready = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 150; i++) begin
      step();
      if (gnt !== g || tx_nbytes !== n || tx_send !== 1'b0 || done !== 2'b00) stable = 1'b0;
    end
    check("wait_done_hold", 64'(stable), 64'(1));
    tx_ready = 1'b1;
    step();
    check("done_pulse", 64'({done, gnt, err}), 64'({g, 2'b00, 2'b00}));
    if (drop) req = req & ~g;
    k = 1;
    step();
    check("done_one_cycle", 64'(done), 64'(0));
    while (busy && k < 100) begin step(); k++; end
    check("gap_len", 64'(k), 64'(24));
  endtask

  initial begin
    int k;
    // rst, req, nb0, nb1, rdy | gnt, done, err, send, txn, busy
    vq.push_back('{1'b0, 2'b00, 11'd0, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 11'd0, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    // zero-length from requester 1
    vq.push_back('{1'b1, 2'b10, 11'd0, 11'd0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0, 11'd0, 1'b1});
    vq.push_back('{1'b1, 2'b10, 11'd0, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 11'd0, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    // timeout: transmitter never leaves idle
    for (int i = 0; i < 8; i++)
      vq.push_back('{1'b1, 2'b01, 11'd5, 11'd0, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 11'd5, 1'b1});
    vq.push_back('{1'b1, 2'b01, 11'd5, 11'd0, 1'b1, 2'b01, 2'b00, 2'b01, 1'b0, 11'd5, 1'b1});
    vq.push_back('{1'b1, 2'b01, 11'd5, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd5, 1'b0});
    vq.push_back('{1'b1, 2'b00, 11'd5, 11'd0, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd5, 1'b0});
    // tie after requester 0 was last -> requester 1; reset; tie after reset -> requester 0
    vq.push_back('{1'b1, 2'b11, 11'd3, 11'd4, 1'b1, 2'b10, 2'b00, 2'b00, 1'b1, 11'd4, 1'b1});
    vq.push_back('{1'b0, 2'b11, 11'd3, 11'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    vq.push_back('{1'b1, 2'b11, 11'd3, 11'd4, 1'b1, 2'b01, 2'b00, 2'b00, 1'b1, 11'd3, 1'b1});
    vq.push_back('{1'b0, 2'b00, 11'd3, 11'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});
    vq.push_back('{1'b1, 2'b00, 11'd3, 11'd4, 1'b1, 2'b00, 2'b00, 2'b00, 1'b0, 11'd0, 1'b0});

    foreach (vq[i]) begin
      rst_n = vq[i].rst_n; req = vq[i].req;
      nbytes0 = vq[i].nb0; nbytes1 = vq[i].nb1; tx_ready = vq[i].rdy;
      step();
      check($sformatf("vec%0d", i),
            64'({gnt, done, err, tx_send, tx_nbytes, busy}),
            64'({vq[i].gnt, vq[i].done, vq[i].err, vq[i].send, vq[i].txn, vq[i].busy}));
    end

    // single frame from requester 0
    req = 2'b01; nbytes0 = 11'd72;
    run_frame(2'b01, 11'd72, 1'b1, 1'b0);

    // simultaneous requests after reset alternate 0,1,0,1
    rst_n = 1'b0; req = 2'b11; nbytes0 = 11'd64; nbytes1 = 11'd100;
    step();
    rst_n = 1'b1;
    run_frame(2'b01, 11'd64,  1'b0, 1'b0);
    run_frame(2'b10, 11'd100, 1'b0, 1'b0);
    run_frame(2'b01, 11'd64,  1'b0, 1'b0);
    run_frame(2'b10, 11'd100, 1'b0, 1'b0);
    req = 2'b00;

    // request and length change after grant must not disturb the frame
    req = 2'b01; nbytes0 = 11'd80;
    run_frame(2'b01, 11'd80, 1'b0, 1'b1);

    // reset while waiting for frame completion
    req = 2'b01; nbytes0 = 11'd50; tx_ready = 1'b1;
    k = 0;
    while (gnt == 2'b00 && k < 60) begin step(); k++; end
    check("rst_seq_grant", 64'(gnt), 64'(2'b01));
    tx_ready = 1'b0;
    step();
    check("rst_seq_wait_done", 64'({gnt, tx_send, busy}), 64'({2'b01, 1'b0, 1'b1}));
    rst_n = 1'b0;
    step();
    check("rst_all_zero", 64'({gnt, done, err, tx_send, tx_nbytes, busy}), 64'(0));
    rst_n = 1'b1; req = 2'b00; tx_ready = 1'b1;
    step();
    check("rst_no_pulse", 64'({gnt, done, err, busy}), 64'(0));
    req = 2'b10; nbytes1 = 11'd33;
    run_frame(2'b10, 11'd33, 1'b1, 1'b0);
    req = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
